// File: rtl/johnson_phase_decoder.sv
// johnson_phase_decoder
//
// Decodes the N-bit Johnson code of an upstream Johnson counter into one of
// 2N phases. Alongside the decode it checks that the sequence is intact: it
// flags illegal codes and skipped, repeated or backward steps, and runs a
// lock state machine. Only a locked decoder drives the one-hot phase output.
// It also counts revolutions while locked.
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   en          sample strobe: the upstream counter advanced, sample code now
//   code        N-bit Johnson code from upstream
//   err_clr     clears err_illegal, err_skip and err_cnt (independent of en)
//   phase       one-hot active phase (2N bits), all-zero unless locked
//   phase_idx   index of the last legal code sampled
//   lock        high while LOCKED
//   rev_tick    one-cycle pulse on a locked wrap from index 2N-1 to 0
//   rev_cnt     revolutions completed while locked, wraps modulo 2^REV_W
//   err_illegal sticky: an illegal code was sampled
//   err_skip    sticky: a legal but non-successor code arrived while locked
//   err_cnt     error events since the last clear, saturating at all-ones

module johnson_phase_decoder #(
    parameter int N      = 4,
    parameter int LOCK_N = 2,
    parameter int REV_W  = 8,
    parameter int ERR_W  = 4,
    localparam int P     = 2 * N,
    localparam int IW    = $clog2(P)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [N-1:0]     code,
    input  logic             err_clr,
    output logic [P-1:0]     phase,
    output logic [IW-1:0]    phase_idx,
    output logic             lock,
    output logic             rev_tick,
    output logic [REV_W-1:0] rev_cnt,
    output logic             err_illegal,
    output logic             err_skip,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    // Legal code for phase p. Phases 0..N fill ones in from the MSB, and
    // phases N+1..2N-1 leave (2N-p) ones at the LSB end.
    function automatic logic [N-1:0] johnson_pattern(input int p);
        logic [N-1:0] pat;
        for (int j = 0; j < N; j++) begin
            if (p <= N) begin
                pat[j] = (j >= N - p);
            end else begin
                pat[j] = (j < P - p);
            end
        end
        return pat;
    endfunction

    state_t          state_reg;
    logic [3:0]      good_cnt_reg;
    logic [IW-1:0]   prev_idx_reg;

    logic [P-1:0]    hit;
    logic            dec_legal;
    logic [IW-1:0]   dec_idx;
    logic [IW-1:0]   exp_idx;
    logic            is_succ;
    logic [P-1:0]    dec_onehot;
    logic            ev_illegal;
    logic            ev_skip;
    logic            ev_any;

    // One comparator per legal code. At most one can match.
    generate
        for (genvar gi = 0; gi < P; gi++) begin : g_match
            localparam logic [N-1:0] PAT = johnson_pattern(gi);
            assign hit[gi] = (code == PAT);
        end
    endgenerate

    always_comb begin
        dec_legal = 1'b0;
        dec_idx   = '0;
        for (int p = 0; p < P; p++) begin
            if (hit[p]) begin
                dec_legal = 1'b1;
                dec_idx   = IW'(p);
            end
        end
    end

    assign exp_idx    = (prev_idx_reg == IW'(P - 1)) ? '0 : prev_idx_reg + IW'(1);
    assign is_succ    = dec_legal && (dec_idx == exp_idx);
    assign dec_onehot = P'(1) << dec_idx;

    // A non-successor code raises a skip error only when it breaks an
    // established lock. During acquisition it just restarts the count.
    assign ev_illegal = en && !dec_legal;
    assign ev_skip    = en && dec_legal && (state_reg == LOCKED) && !is_succ;
    assign ev_any     = ev_illegal || ev_skip;

    assign lock = (state_reg == LOCKED);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= UNLOCKED;
            good_cnt_reg <= '0;
            prev_idx_reg <= '0;
            phase        <= '0;
            phase_idx    <= '0;
            rev_tick     <= 1'b0;
            rev_cnt      <= '0;
            err_illegal  <= 1'b0;
            err_skip     <= 1'b0;
            err_cnt      <= '0;
        end else begin
            rev_tick <= 1'b0;

            if (en) begin
                if (!dec_legal) begin
                    // phase_idx and prev_idx keep the last legal value.
                    state_reg    <= UNLOCKED;
                    good_cnt_reg <= '0;
                    phase        <= '0;
                end else begin
                    phase_idx    <= dec_idx;
                    prev_idx_reg <= dec_idx;
                    case (state_reg)
                        UNLOCKED: begin
                            state_reg    <= ACQUIRE;
                            good_cnt_reg <= '0;
                            phase        <= '0;
                        end
                        ACQUIRE: begin
                            if (is_succ) begin
                                good_cnt_reg <= good_cnt_reg + 4'd1;
                                if (good_cnt_reg + 4'd1 == 4'(LOCK_N)) begin
                                    state_reg <= LOCKED;
                                    phase     <= dec_onehot;
                                end else begin
                                    phase     <= '0;
                                end
                            end else begin
                                good_cnt_reg <= '0;
                                phase        <= '0;
                            end
                        end
                        LOCKED: begin
                            if (is_succ) begin
                                phase <= dec_onehot;
                                // A successor of index 0 means the wrap from 2N-1.
                                if (dec_idx == '0) begin
                                    rev_tick <= 1'b1;
                                    rev_cnt  <= rev_cnt + REV_W'(1);
                                end
                            end else begin
                                state_reg    <= ACQUIRE;
                                good_cnt_reg <= '0;
                                phase        <= '0;
                            end
                        end
                        default: begin
                            state_reg    <= UNLOCKED;
                            good_cnt_reg <= '0;
                            phase        <= '0;
                        end
                    endcase
                end
            end

            // An error in the same cycle as a clear survives it and counts as
            // the first event after the clear.
            if (err_clr) begin
                err_illegal <= ev_illegal;
                err_skip    <= ev_skip;
                err_cnt     <= ev_any ? ERR_W'(1) : '0;
            end else if (ev_any) begin
                if (ev_illegal) begin
                    err_illegal <= 1'b1;
                end
                if (ev_skip) begin
                    err_skip <= 1'b1;
                end
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + ERR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Directed testbench for johnson_phase_decoder (N=4, LOCK_N=2).
module tb_johnson_phase_decoder;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic [3:0] code;
    logic       err_clr;
    logic [7:0] phase;
    logic [2:0] phase_idx;
    logic       lock;
    logic       rev_tick;
    logic [7:0] rev_cnt;
    logic       err_illegal;
    logic       err_skip;
    logic [3:0] err_cnt;

    int checks   = 0;
    int failures = 0;

    johnson_phase_decoder #(
        .N(4), .LOCK_N(2), .REV_W(8), .ERR_W(4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .code        (code),
        .err_clr     (err_clr),
        .phase       (phase),
        .phase_idx   (phase_idx),
        .lock        (lock),
        .rev_tick    (rev_tick),
        .rev_cnt     (rev_cnt),
        .err_illegal (err_illegal),
        .err_skip    (err_skip),
        .err_cnt     (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] code;
        logic       clr;
        logic [7:0] ph;
        logic [2:0] idx;
        logic       lk;
        logic       tick;
        logic [7:0] rev;
        logic       ei;
        logic       es;
        logic [3:0] ec;
    } vec_t;

    localparam int NV = 20;
    vec_t vt [NV];

    // Johnson code for each phase index, written out by hand.
    logic [3:0] codes [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] ph, input logic [2:0] idx,
                              input logic lk, input logic tick, input logic [7:0] rev,
                              input logic ei, input logic es, input logic [3:0] ec);
        chk({tag, ".phase"},       32'(phase),       32'(ph));
        chk({tag, ".phase_idx"},   32'(phase_idx),   32'(idx));
        chk({tag, ".lock"},        32'(lock),        32'(lk));
        chk({tag, ".rev_tick"},    32'(rev_tick),    32'(tick));
        chk({tag, ".rev_cnt"},     32'(rev_cnt),     32'(rev));
        chk({tag, ".err_illegal"}, 32'(err_illegal), 32'(ei));
        chk({tag, ".err_skip"},    32'(err_skip),    32'(es));
        chk({tag, ".err_cnt"},     32'(err_cnt),     32'(ec));
    endtask

    // Drive one cycle's inputs, let one edge pass, then settle before checking.
    task automatic step(input logic e, input logic [3:0] c, input logic cl);
        en      = e;
        code    = c;
        err_clr = cl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_rev;
        logic       exp_tick;
        int         i;

        codes[0] = 4'b0000; codes[1] = 4'b1000; codes[2] = 4'b1100; codes[3] = 4'b1110;
        codes[4] = 4'b1111; codes[5] = 4'b0111; codes[6] = 4'b0011; codes[7] = 4'b0001;

        //            en  code     clr  phase         idx  lk tk rev ei es ec
        vt[0]  = '{1'b1, 4'b0000, 1'b0, 8'b0000_0000, 3'd0, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{1'b1, 4'b1000, 1'b0, 8'b0000_0000, 3'd1, 0, 0, 0, 0, 0, 0};
        vt[2]  = '{1'b1, 4'b1100, 1'b0, 8'b0000_0100, 3'd2, 1, 0, 0, 0, 0, 0};
        vt[3]  = '{1'b1, 4'b1110, 1'b0, 8'b0000_1000, 3'd3, 1, 0, 0, 0, 0, 0};
        vt[4]  = '{1'b1, 4'b1111, 1'b0, 8'b0001_0000, 3'd4, 1, 0, 0, 0, 0, 0};
        vt[5]  = '{1'b1, 4'b0111, 1'b0, 8'b0010_0000, 3'd5, 1, 0, 0, 0, 0, 0};
        vt[6]  = '{1'b1, 4'b0011, 1'b0, 8'b0100_0000, 3'd6, 1, 0, 0, 0, 0, 0};
        vt[7]  = '{1'b1, 4'b0001, 1'b0, 8'b1000_0000, 3'd7, 1, 0, 0, 0, 0, 0};
        vt[8]  = '{1'b1, 4'b0000, 1'b0, 8'b0000_0001, 3'd0, 1, 1, 1, 0, 0, 0};
        vt[9]  = '{1'b0, 4'b1010, 1'b0, 8'b0000_0001, 3'd0, 1, 0, 1, 0, 0, 0};
        vt[10] = '{1'b0, 4'b0101, 1'b0, 8'b0000_0001, 3'd0, 1, 0, 1, 0, 0, 0};
        vt[11] = '{1'b1, 4'b1000, 1'b0, 8'b0000_0010, 3'd1, 1, 0, 1, 0, 0, 0};
        vt[12] = '{1'b1, 4'b1100, 1'b0, 8'b0000_0100, 3'd2, 1, 0, 1, 0, 0, 0};
        vt[13] = '{1'b1, 4'b1110, 1'b0, 8'b0000_1000, 3'd3, 1, 0, 1, 0, 0, 0};
        vt[14] = '{1'b1, 4'b0111, 1'b0, 8'b0000_0000, 3'd5, 0, 0, 1, 0, 1, 1};
        vt[15] = '{1'b1, 4'b0011, 1'b0, 8'b0000_0000, 3'd6, 0, 0, 1, 0, 1, 1};
        vt[16] = '{1'b1, 4'b0001, 1'b0, 8'b1000_0000, 3'd7, 1, 0, 1, 0, 1, 1};
        vt[17] = '{1'b1, 4'b1010, 1'b0, 8'b0000_0000, 3'd7, 0, 0, 1, 1, 1, 2};
        vt[18] = '{1'b1, 4'b1010, 1'b1, 8'b0000_0000, 3'd7, 0, 0, 1, 1, 0, 1};
        vt[19] = '{1'b0, 4'b0000, 1'b1, 8'b0000_0000, 3'd7, 0, 0, 1, 0, 0, 0};

        reset_n = 1'b0;
        en      = 1'b0;
        code    = 4'b0000;
        err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 8'h00, 3'd0, 0, 0, 8'd0, 0, 0, 4'd0);
        $display("reset state checked");
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven main sequence: lock, revolution, en gating, skip,
        // relock, illegal code, err_clr against a simultaneous error.
        for (int v = 0; v < NV; v++) begin
            step(vt[v].en, vt[v].code, vt[v].clr);
            check_outs($sformatf("vec%0d", v), vt[v].ph, vt[v].idx, vt[v].lk, vt[v].tick,
                       vt[v].rev, vt[v].ei, vt[v].es, vt[v].ec);
            $display("vec %0d en=%0b code=%b clr=%0b -> phase=%b idx=%0d lock=%0b tick=%0b rev=%0d ei=%0b es=%0b ec=%0d",
                     v, vt[v].en, vt[v].code, vt[v].clr, phase, phase_idx, lock, rev_tick,
                     rev_cnt, err_illegal, err_skip, err_cnt);
        end

        // err_cnt saturation under repeated illegal codes.
        for (int k = 1; k <= 17; k++) begin
            step(1'b1, 4'b1010, 1'b0);
            check_outs($sformatf("sat%0d", k), 8'h00, 3'd7, 0, 0, 8'd1, 1, 0,
                       (k >= 15) ? 4'd15 : 4'(k));
            $display("sat %0d err_cnt=%0d", k, err_cnt);
        end
        step(1'b0, 4'b1010, 1'b1);
        check_outs("satclr", 8'h00, 3'd7, 0, 0, 8'd1, 0, 0, 4'd0);
        $display("err_clr alone -> err_cnt=%0d", err_cnt);

        // Lock again, then an asynchronous reset between edges.
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b1000, 1'b0);
        step(1'b1, 4'b1100, 1'b0);
        check_outs("prelock", 8'b0000_0100, 3'd2, 1, 0, 8'd1, 0, 0, 4'd0);
        en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_outs("async_rst", 8'h00, 3'd0, 0, 0, 8'd0, 0, 0, 4'd0);
        $display("async reset mid-lock: lock=%0b phase=%b rev=%0d", lock, phase, rev_cnt);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;

        step(1'b1, 4'b0000, 1'b0);
        check_outs("relock1", 8'h00, 3'd0, 0, 0, 8'd0, 0, 0, 4'd0);
        step(1'b1, 4'b1000, 1'b0);
        check_outs("relock2", 8'h00, 3'd1, 0, 0, 8'd0, 0, 0, 4'd0);
        step(1'b1, 4'b1100, 1'b0);
        check_outs("relock3", 8'b0000_0100, 3'd2, 1, 0, 8'd0, 0, 0, 4'd0);
        $display("relock after reset: lock=%0b phase_idx=%0d", lock, phase_idx);

        // 256 locked revolutions: rev_cnt must wrap back to 0.
        exp_rev = 8'd0;
        for (int s = 0; s < 256 * 8; s++) begin
            i = (3 + s) % 8;
            step(1'b1, codes[i], 1'b0);
            exp_tick = (i == 0);
            if (exp_tick) exp_rev = exp_rev + 8'd1;
            chk($sformatf("rev_s%0d.rev_tick", s), 32'(rev_tick), 32'(exp_tick));
            chk($sformatf("rev_s%0d.rev_cnt", s), 32'(rev_cnt), 32'(exp_rev));
            chk($sformatf("rev_s%0d.phase", s), 32'(phase), 32'(8'd1 << i));
            if (exp_tick) $display("revolution done rev_cnt=%0d", rev_cnt);
        end
        check_outs("wrap_end", 8'b0000_0100, 3'd2, 1, 0, 8'd0, 0, 0, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
